// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the frame configuration loader.
// Command word layout: {col, start, count}.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_LOAD,
    ST_STROBE,
    ST_HOLD,
    ST_CHECK
  } state_t;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;
  localparam logic [7:0]  END_COL   = 8'hFF;

  localparam int CMD_COL_LSB   = 24;
  localparam int CMD_COL_W     = 8;
  localparam int CMD_START_LSB = 16;
  localparam int CMD_START_W   = 8;
  localparam int CMD_CNT_LSB   = 0;
  localparam int CMD_CNT_W     = 16;

endpackage

// File: rtl/cfg_onehot_decoder.sv
// Index to one-hot decoder with enable.
// Out-of-range indices decode to all zeros.
module cfg_onehot_decoder #(
  parameter int N = 16,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W-1:0] i_idx,
  input  logic         i_en,
  output logic [N-1:0] o_onehot
);

  // one bit per output, set only when enabled and selected
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N; i++) begin
      o_onehot[i] = i_en && (i_idx == W'(i));
    end
  end

endmodule

// File: rtl/frame_config_loader.sv
// Bitstream word stream to fabric frame latch driver.
// Optional check word per command: define CFG_LOADER_CRC_EN.
module frame_config_loader
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int NUM_COLS   = 16,
  parameter int MAX_FRAMES = 20
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [WORD_W-1:0]     FrameData,
  output logic [NUM_COLS-1:0]   ColSelect,
  output logic [MAX_FRAMES-1:0] FrameStrobe,
  output logic                  cfg_done,
  output logic                  cfg_error
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int FR_W  = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [7:0]  NCOLS_B = 8'(NUM_COLS);
  localparam logic [16:0] NFR_B   = 17'(MAX_FRAMES);

  state_t r_state;
  state_t w_next;

  logic [COL_W-1:0]     r_col;
  logic [FR_W-1:0]      r_frame;
  logic [CMD_CNT_W-1:0] r_left;
  logic [WORD_W-1:0]    r_data;
  logic                 r_done;
  logic                 r_err;

  logic                   w_accept;
  logic                   w_sync;
  logic                   w_end;
  logic                   w_noop;
  logic                   w_bad;
  logic                   w_last;
  logic                   w_col_en;
  logic                   w_strb_en;
  logic [CMD_COL_W-1:0]   w_col;
  logic [CMD_START_W-1:0] w_start;
  logic [CMD_CNT_W-1:0]   w_cnt;
  logic [16:0]            w_span;

  assign w_accept = s_valid & s_ready;
  assign w_sync   = (s_data == SYNC_WORD);
  assign w_col    = s_data[CMD_COL_LSB +: CMD_COL_W];
  assign w_start  = s_data[CMD_START_LSB +: CMD_START_W];
  assign w_cnt    = s_data[CMD_CNT_LSB +: CMD_CNT_W];
  assign w_span   = 17'(w_start) + 17'(w_cnt);
  assign w_end    = (w_col == END_COL);
  assign w_noop   = (w_cnt == '0);
  assign w_bad    = (w_col >= NCOLS_B) || (w_span > NFR_B);
  assign w_last   = (r_left == CMD_CNT_W'(1));

`ifdef CFG_LOADER_CRC_EN
  logic [31:0] r_crc;
  logic        w_crc_ok;

  assign w_crc_ok = (s_data == r_crc);

  // running XOR of the data words of the current command
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_crc <= '0;
    end else if (r_state == ST_CMD && w_accept) begin
      r_crc <= '0;
    end else if (r_state == ST_LOAD && w_accept) begin
      r_crc <= r_crc ^ s_data;
    end
  end
`endif

  // state register
  always_ff @(posedge CLK) begin
    if (!resetn) r_state <= ST_HUNT;
    else         r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_HUNT: begin
        if (w_accept && w_sync) w_next = ST_CMD;
      end
      ST_CMD: begin
        if (w_accept) begin
          if (w_end)       w_next = ST_HUNT;
          else if (w_noop) w_next = ST_CMD;
          else if (w_bad)  w_next = ST_HUNT;
          else             w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept) w_next = ST_STROBE;
      end
      ST_STROBE: w_next = ST_HOLD;
      ST_HOLD: begin
        if (w_last) begin
`ifdef CFG_LOADER_CRC_EN
          w_next = ST_CHECK;
`else
          w_next = ST_CMD;
`endif
        end else begin
          w_next = ST_LOAD;
        end
      end
`ifdef CFG_LOADER_CRC_EN
      ST_CHECK: begin
        if (w_accept) w_next = w_crc_ok ? ST_CMD : ST_HUNT;
      end
`endif
      default: w_next = ST_HUNT;
    endcase
  end

  // handshake and latch-enable decode from state
  always_comb begin
    s_ready   = 1'b0;
    w_col_en  = 1'b0;
    w_strb_en = 1'b0;
    unique case (r_state)
      ST_HUNT:   s_ready = 1'b1;
      ST_CMD:    s_ready = 1'b1;
      ST_LOAD: begin
        s_ready  = 1'b1;
        w_col_en = 1'b1;
      end
      ST_STROBE: begin
        w_col_en  = 1'b1;
        w_strb_en = 1'b1;
      end
      ST_HOLD:   w_col_en = 1'b1;
      ST_CHECK:  s_ready = 1'b1;
      default:   s_ready = 1'b0;
    endcase
  end

  // command fields, frame counters, data and status flags
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_col   <= '0;
      r_frame <= '0;
      r_left  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_HUNT: begin
          if (w_accept && w_sync) r_err <= 1'b0;
        end
        ST_CMD: begin
          if (w_accept) begin
            if (w_end) begin
              r_done <= 1'b1;
            end else if (!w_noop) begin
              if (w_bad) begin
                r_err <= 1'b1;
              end else begin
                r_col   <= w_col[COL_W-1:0];
                r_frame <= w_start[FR_W-1:0];
                r_left  <= w_cnt;
              end
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) r_data <= s_data[WORD_W-1:0];
        end
        ST_HOLD: begin
          r_frame <= r_frame + FR_W'(1);
          r_left  <= r_left - CMD_CNT_W'(1);
        end
        ST_CHECK: begin
`ifdef CFG_LOADER_CRC_EN
          if (w_accept && !w_crc_ok) r_err <= 1'b1;
`endif
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign FrameData = r_data;
  assign cfg_done  = r_done;
  assign cfg_error = r_err;

  cfg_onehot_decoder #(.N(NUM_COLS)) u_col_dec (
    .i_idx    (r_col),
    .i_en     (w_col_en),
    .o_onehot (ColSelect)
  );

  cfg_onehot_decoder #(.N(MAX_FRAMES)) u_strb_dec (
    .i_idx    (r_frame),
    .i_en     (w_strb_en),
    .o_onehot (FrameStrobe)
  );

endmodule

// File: tb/tb_frame_config_loader.sv
// Scoreboard bench for frame_config_loader.
// Word-level reference model predicts output events.
module tb_frame_config_loader;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  localparam int EV_STRB = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;
  localparam int EV_CLR  = 3;

  typedef struct {
    int          kind;
    logic [15:0] cs;
    logic [19:0] fs;
    logic [31:0] fd;
  } ev_t;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] FrameData;
  logic [15:0] ColSelect;
  logic [19:0] FrameStrobe;
  logic        cfg_done;
  logic        cfg_error;

  int checks = 0;
  int failures = 0;
  ev_t q[$];

  // model state: 0 hunt, 1 cmd, 2 data, 3 check
  int          m_mode = 0;
  bit          m_err = 0;
  int          m_col, m_frame, m_left;
  logic [31:0] m_x;

  frame_config_loader dut (
    .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .FrameData(FrameData), .ColSelect(ColSelect),
    .FrameStrobe(FrameStrobe), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push(input int k, input int col, input int fr,
                      input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.cs = 16'd1 << col;
    e.fs = 20'd1 << fr;
    e.fd = d;
    if (k != EV_STRB) begin
      e.cs = '0; e.fs = '0; e.fd = '0;
    end
    q.push_back(e);
  endtask

  task automatic model(input logic [31:0] w);
    int col = int'(w[31:24]);
    int st  = int'(w[23:16]);
    int cnt = int'(w[15:0]);
    case (m_mode)
      0: if (w == SYNC) begin
        if (m_err) push(EV_CLR, 0, 0, 0);
        m_err = 0;
        m_mode = 1;
      end
      1: begin
        if (col == 255) begin
          push(EV_DONE, 0, 0, 0);
          m_mode = 0;
        end else if (cnt == 0) begin
          m_mode = 1;
        end else if (col >= 16 || st + cnt > 20) begin
          push(EV_ERR, 0, 0, 0);
          m_err = 1;
          m_mode = 0;
        end else begin
          m_col = col; m_frame = st; m_left = cnt; m_x = '0;
          m_mode = 2;
        end
      end
      2: begin
        push(EV_STRB, m_col, m_frame, w);
        m_frame++;
        m_left--;
        m_x ^= w;
`ifdef CFG_LOADER_CRC_EN
        if (m_left == 0) m_mode = 3;
`else
        if (m_left == 0) m_mode = 1;
`endif
      end
      default: begin
        if (w != m_x) begin
          push(EV_ERR, 0, 0, 0);
          m_err = 1;
          m_mode = 0;
        end else begin
          m_mode = 1;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_evt(input int k);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL event: got unexpected kind=%0d, required no event", k);
    end else begin
      e = q.pop_front();
      if (e.kind != k || (k == EV_STRB && (e.cs !== ColSelect ||
          e.fs !== FrameStrobe || e.fd !== FrameData))) begin
        failures++;
        $display("FAIL event: got kind=%0d col=%h strb=%h data=%h, required kind=%0d col=%h strb=%h data=%h",
                 k, ColSelect, FrameStrobe, FrameData, e.kind, e.cs, e.fs, e.fd);
      end
    end
  endtask

  // monitor: pops expected events as the DUT presents them
  int  cyc = 0;
  int  last_strb = -100;
  bit  prev_err = 0;
  always @(negedge CLK) begin
    if (!resetn) begin
      prev_err = 0;
      last_strb = -100;
    end else begin
      cyc++;
      if (FrameStrobe != '0) begin
        checks++;
        if ($countones(FrameStrobe) != 1 || ColSelect == '0) begin
          failures++;
          $display("FAIL strobe_shape: got strb=%h col=%h, required one-hot with col set",
                   FrameStrobe, ColSelect);
        end
        if (last_strb >= 0) begin
          checks++;
          if (cyc - last_strb < 3) begin
            failures++;
            $display("FAIL strobe_spacing: got %0d cycles, required >=3", cyc - last_strb);
          end
        end
        last_strb = cyc;
        chk_evt(EV_STRB);
      end
      if (cfg_done) chk_evt(EV_DONE);
      if (cfg_error && !prev_err) chk_evt(EV_ERR);
      if (!cfg_error && prev_err) chk_evt(EV_CLR);
      prev_err = cfg_error;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      s_valid = 1'b0;
      s_data = $urandom;
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    bit acc = 0;
    while (!acc) begin
      @(negedge CLK);
      s_data = w;
      s_valid = 1'b1;
      acc = s_ready;
      @(posedge CLK);
      n++;
      if (!acc && n > 40) begin
        checks++;
        failures++;
        $display("FAIL handshake: got s_ready=0 for %0d cycles, required accept", n);
        return;
      end
    end
    model(w);
  endtask

  function automatic logic [31:0] junk();
    logic [31:0] w = $urandom;
    if (w == SYNC) w = w ^ 32'h1;
    return w;
  endfunction

  function automatic logic [31:0] cmd(input int c, input int s, input int n);
    return {8'(c), 8'(s), 16'(n)};
  endfunction

  task automatic cmd_data(input int c, input int s, input int n, input bit gaps);
    logic [31:0] x = '0;
    logic [31:0] d;
    send(cmd(c, s, n));
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      d = $urandom;
      x ^= d;
      send(d);
    end
`ifdef CFG_LOADER_CRC_EN
    if ($urandom_range(0, 4) == 0) x ^= 32'h0000_0100;
    send(x);
`else
    checks = checks + 0 * int'(x[0]);
`endif
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_framedata", FrameData, 32'h0);
    chk("rst_colselect", {16'h0, ColSelect}, 32'h0);
    chk("rst_strobe", {12'h0, FrameStrobe}, 32'h0);
    chk("rst_done", {31'h0, cfg_done}, 32'h0);
    chk("rst_error", {31'h0, cfg_error}, 32'h0);
    resetn = 1'b1;

    repeat (3) send(junk());
    send(SYNC);
    send(cmd(2, 0, 2));
    send(32'h1234_5678);
    send(32'h9ABC_DEF0);
`ifdef CFG_LOADER_CRC_EN
    send(32'h1234_5678 ^ 32'h9ABC_DEF0);
`endif

    send(cmd(16, 0, 1));
    repeat (2) send(junk());
    send(SYNC);
    send(cmd(0, 19, 2));
    repeat (2) send(junk());
    send(SYNC);
    send(cmd(9, 3, 0));
    send(cmd(5, 18, 2));
    send(32'hCAFE_0001);
    send(32'hCAFE_0002);
`ifdef CFG_LOADER_CRC_EN
    send(32'h0000_0003);
`endif
    send(cmd(7, 4, 1));
    send(SYNC);
`ifdef CFG_LOADER_CRC_EN
    send(SYNC);
`endif
    send(cmd(255, 0, 0));
    idle(2);
    chk("hunt_ready", {31'h0, s_ready}, 32'h1);
    send(junk());

`ifdef CFG_LOADER_CRC_EN
    send(SYNC);
    send(cmd(1, 0, 2));
    send(32'hA5A5_A5A5);
    send(32'h0F0F_0F0F);
    send(32'hAAAA_AAAA);
    send(cmd(1, 2, 2));
    send(32'hA5A5_A5A5);
    send(32'h0F0F_0F0F);
    send(32'h0000_0000);
`endif

    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 9);
      int s = $urandom_range(0, 19);
      if (m_mode == 0) begin
        repeat ($urandom_range(0, 2)) send(junk());
        send(SYNC);
      end
      if (r == 0)      send(cmd($urandom_range(16, 254), s, 1));
      else if (r == 1) send(cmd($urandom_range(0, 15), s, 21 - s + $urandom_range(0, 300)));
      else if (r == 2) send(cmd($urandom_range(0, 15), s, 0));
      else cmd_data($urandom_range(0, 15), s, $urandom_range(1, 20 - s), 1'b1);
    end
    if (m_mode == 0) send(SYNC);
    send(cmd(255, 0, 0));

    send(SYNC);
    send(cmd(3, 0, 2));
    send(32'h5555_AAAA);
    @(negedge CLK);
    #2 resetn = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    s_valid = 1'b0;
    chk("rstmid_strobe", {12'h0, FrameStrobe}, 32'h0);
    chk("rstmid_colselect", {16'h0, ColSelect}, 32'h0);
    chk("rstmid_framedata", FrameData, 32'h0);
    chk("rstmid_ready", {31'h0, s_ready}, 32'h1);
    m_mode = 0;
    m_err = 0;
    #2 resetn = 1'b1;
    send(junk());
    send(SYNC);
    send(cmd(4, 10, 1));
    send(32'h0BAD_F00D);
`ifdef CFG_LOADER_CRC_EN
    send(32'h0BAD_F00D);
`endif

    idle(10);
    chk("queue_empty", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
